// File: rtl/mopshub_spi_pkg.sv
// Shared types and constants for the MOPS-Hub SPI receive path.
// Used by spi_rec_buffer_ctrl and its optional watchdog (SPI_TIMEOUT_EN).
package mopshub_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_REQ   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int DEF_FIRST_ADDR = 3;
  localparam int DEF_CLEAR_ADDR = 0;
  localparam int FRAME_W        = 76;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rec_timeout_cnt.sv
// REQ-state watchdog for spi_rec_buffer_ctrl; only instantiated when SPI_TIMEOUT_EN is defined.
// Counts while enabled, holds zero while cleared, flags expiry at TIMEOUT_CYC-1.
module spi_rec_timeout_cnt
  import mopshub_spi_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = max_int(10, $clog2(TIMEOUT_CYC));
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_rec_buffer_ctrl.sv
// Sequencer that clears the SPI receive buffer, fetches NUM_BYTES bytes into it and
// holds frame_ready until acked. Optional REQ watchdog/ERR state via SPI_TIMEOUT_EN.
module spi_rec_buffer_ctrl
  import mopshub_spi_pkg::*;
#(
  parameter int FIRST_ADDR  = DEF_FIRST_ADDR,
  parameter int NUM_BYTES   = 5,
  parameter int CLEAR_ADDR  = DEF_CLEAR_ADDR,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       spi_byte_req,
  output logic [2:0] spi_byte_idx,
  input  logic       spi_byte_valid,
  output logic       buffer_en,
  output logic [4:0] addr,
  output logic       busy,
  output logic       frame_ready,
  input  logic       frame_ack,
  output logic       err
);

  localparam logic [4:0] FIRST_A  = 5'(FIRST_ADDR);
  localparam logic [4:0] CLEAR_A  = 5'(CLEAR_ADDR);
  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       timeout_exp;

`ifdef SPI_TIMEOUT_EN
  spi_rec_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != ST_REQ),
    .en_i     (state_q == ST_REQ),
    .expired_o(timeout_exp)
  );
  assign err = (state_q == ST_ERR);
`else
  // Without the watchdog REQ waits forever; the comparison is always false.
  assign timeout_exp = (TIMEOUT_CYC < 0);
  assign err         = 1'b0;
`endif

  assign busy        = (state_q != ST_IDLE);
  assign frame_ready = (state_q == ST_DONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    spi_byte_req = 1'b0;
    spi_byte_idx = 3'd0;
    buffer_en    = 1'b0;
    addr         = CLEAR_A;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        buffer_en = 1'b1;
        cnt_d     = 3'd0;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        spi_byte_req = 1'b1;
        spi_byte_idx = cnt_q;
        addr         = FIRST_A + {2'b00, cnt_q};
        // The buffer latches the SPI data byte on the same edge the master flags it valid.
        buffer_en    = spi_byte_valid;
        if (spi_byte_valid) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            state_d = ST_GAP;
          end
        end else if (timeout_exp) begin
          state_d = ST_ERR;
        end
      end
      ST_GAP: begin
        state_d = ST_REQ;
      end
      ST_DONE, ST_ERR: begin
        if (frame_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_rec_buffer_ctrl.sv
// Scoreboard bench for spi_rec_buffer_ctrl: stimulus queues expected buffer writes and
// frame_ready events, a negedge monitor pops and compares them. Timeout case under SPI_TIMEOUT_EN.
module tb_spi_rec_buffer_ctrl;

  localparam logic [4:0] FIRST_A = 5'd3;
  localparam logic [4:0] CLEAR_A = 5'd0;
  localparam int         NB      = 5;
  localparam int         K_CLR   = 0;
  localparam int         K_WR    = 1;
  localparam int         K_FR    = 2;

  typedef struct {
    int         kind;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, spi_byte_valid = 1'b0, frame_ack = 1'b0;
  logic       spi_byte_req, buffer_en, busy, frame_ready, err;
  logic [2:0] spi_byte_idx;
  logic [4:0] addr;
  logic [7:0] spi_data = 8'hEE;

  logic       start_1 = 1'b0, valid_1 = 1'b0, ack_1 = 1'b0;
  logic       req_1, buffer_en_1, busy_1, frame_ready_1, err_1;
  logic [2:0] idx_1;
  logic [4:0] addr_1;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  ev_t        exp_q[$];
  logic [7:0] buf_m[0:31];
  logic [7:0] frame_bytes[0:NB-1];
  logic       fr_prev = 1'b0;

  always #5 clk = ~clk;

  spi_rec_buffer_ctrl #(
    .FIRST_ADDR(3), .NUM_BYTES(NB), .CLEAR_ADDR(0), .TIMEOUT_CYC(16)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .spi_byte_req(spi_byte_req),
    .spi_byte_idx(spi_byte_idx), .spi_byte_valid(spi_byte_valid), .buffer_en(buffer_en),
    .addr(addr), .busy(busy), .frame_ready(frame_ready), .frame_ack(frame_ack), .err(err)
  );

  spi_rec_buffer_ctrl #(
    .FIRST_ADDR(3), .NUM_BYTES(1), .CLEAR_ADDR(0), .TIMEOUT_CYC(16)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start_1), .spi_byte_req(req_1),
    .spi_byte_idx(idx_1), .spi_byte_valid(valid_1), .buffer_en(buffer_en_1),
    .addr(addr_1), .busy(busy_1), .frame_ready(frame_ready_1), .frame_ack(ack_1), .err(err_1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 20) begin
      if (spi_byte_req === 1'b1) ok = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL wait_req: spi_byte_req stayed low for %0d cycles, required 1", k);
    end
  endtask

  // Monitor: every buffer write and every frame_ready rise must match the next queued event.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  act_kind;
    if (buffer_en === 1'b1) begin
      act_kind = (addr == CLEAR_A) ? K_CLR : K_WR;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: buffer_en=1 addr=%0d, required no write", addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_kind", act_kind, e.kind);
        chk("wr_addr", addr, e.addr);
        if (e.kind == K_WR) chk("wr_data", spi_data, e.data);
      end
      if (addr == CLEAR_A) begin
        for (int s = 0; s < NB; s++) buf_m[FIRST_A + s] = 8'h00;
      end else begin
        buf_m[addr] = spi_data;
      end
    end
    if (frame_ready === 1'b1 && !fr_prev) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_frame_ready: rose with nothing queued, required no event");
      end else begin
        e = exp_q.pop_front();
        chk("frame_event_kind", K_FR, e.kind);
      end
    end
    fr_prev = (frame_ready === 1'b1);
  end

  // One frame on the main DUT; disturb adds ignored start/ack in REQ and a stray valid in GAP.
  task automatic run_frame(input bit disturb, input int abort_after);
    bit ok;
    exp_q.push_back('{kind: K_CLR, addr: CLEAR_A, data: 8'h00});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_busy", busy, 1);
    tick();
    chk("start_to_req_latency", spi_byte_req, 1);
    for (int s = 0; s < NB; s++) chk("clear_zeroes_slot", buf_m[FIRST_A + s], 8'h00);
    for (int i = 0; i < NB; i++) begin
      wait_req(ok);
      if (!ok) return;
      chk("req_idx", spi_byte_idx, i);
      chk("req_addr", addr, FIRST_A + i);
      if (disturb && i == 0) begin
        start     = 1'b1;
        frame_ack = 1'b1;
        tick();
        start     = 1'b0;
        frame_ack = 1'b0;
        tick();
        tick();
      end else begin
        repeat (3) tick();
      end
      chk("req_held", spi_byte_req, 1);
      spi_data       = frame_bytes[i];
      spi_byte_valid = 1'b1;
      exp_q.push_back('{kind: K_WR, addr: FIRST_A + 5'(i), data: frame_bytes[i]});
      if (i == NB - 1) exp_q.push_back('{kind: K_FR, addr: 5'd0, data: 8'h00});
      tick();
      spi_byte_valid = 1'b0;
      spi_data       = 8'hEE;
      if (i == abort_after) begin
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", spi_byte_req, 0);
        chk("rst_addr", addr, CLEAR_A);
        tick();
        rst = 1'b1;
        return;
      end
      if (i < NB - 1) begin
        chk("gap_req_low", spi_byte_req, 0);
        if (disturb) begin
          spi_byte_valid = 1'b1;
          #1;
          chk("gap_valid_ignored", buffer_en, 0);
          spi_byte_valid = 1'b0;
        end
      end else begin
        chk("frame_ready_after_last", frame_ready, 1);
      end
    end
  endtask

  task automatic check_buf(input string name);
    for (int s = 0; s < NB; s++) chk(name, buf_m[FIRST_A + s], frame_bytes[s]);
  endtask

  initial begin
    for (int s = 0; s < 32; s++) buf_m[s] = 8'hFF;
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_req", spi_byte_req, 0);
    chk("reset_frame_ready", frame_ready, 0);
    chk("reset_buffer_en", buffer_en, 0);
    chk("reset_addr", addr, CLEAR_A);
    chk("reset_err", err, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Frame 1: A1..A5, each byte 3 cycles after its request.
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'hA1 + 8'(i);
    run_frame(1'b0, -1);
    check_buf("frame1_bytes");
    repeat (2) tick();
    chk("ready_held", frame_ready, 1);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_clears_ready", frame_ready, 0);
    chk("ack_idle", busy, 0);

    // Stray valid while IDLE must not write.
    spi_data       = 8'h5A;
    spi_byte_valid = 1'b1;
    #1;
    chk("idle_valid_ignored", buffer_en, 0);
    tick();
    spi_byte_valid = 1'b0;
    spi_data       = 8'hEE;
    chk("idle_valid_no_start", busy, 0);

    // Frame 2: disturbances, then start+ack together in DONE.
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'hB1 + 8'(i);
    run_frame(1'b1, -1);
    check_buf("frame2_bytes");
    start     = 1'b1;
    frame_ack = 1'b1;
    tick();
    start     = 1'b0;
    frame_ack = 1'b0;
    chk("done_ack_ready", frame_ready, 0);
    chk("done_ack_busy", busy, 0);
    repeat (3) tick();
    chk("done_start_dropped", busy, 0);

    // Frame 3 aborted by reset after byte 2, frame 4 must start from a cleared buffer.
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'hA1 + 8'(i);
    run_frame(1'b0, 1);
    chk("abort_idle", busy, 0);
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'h11 + 8'(i);
    run_frame(1'b0, -1);
    check_buf("frame4_bytes");
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("frame4_idle", busy, 0);

    // Single-byte instance: CLEAR, REQ, DONE with no GAP.
    start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    chk("nb1_clear_en", buffer_en_1, 1);
    chk("nb1_clear_addr", addr_1, CLEAR_A);
    tick();
    chk("nb1_req", req_1, 1);
    chk("nb1_req_addr", addr_1, FIRST_A);
    chk("nb1_req_idx", idx_1, 0);
    valid_1 = 1'b1;
    #1;
    chk("nb1_write_en", buffer_en_1, 1);
    tick();
    valid_1 = 1'b0;
    chk("nb1_frame_ready", frame_ready_1, 1);
    chk("nb1_busy", busy_1, 1);
    ack_1 = 1'b1;
    tick();
    ack_1 = 1'b0;
    chk("nb1_idle", busy_1, 0);

`ifdef SPI_TIMEOUT_EN
    begin : timeout_case
      bit ok;
      exp_q.push_back('{kind: K_CLR, addr: CLEAR_A, data: 8'h00});
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
        wait_req(ok);
        repeat (3) tick();
        spi_data       = 8'hC1 + 8'(i);
        spi_byte_valid = 1'b1;
        exp_q.push_back('{kind: K_WR, addr: FIRST_A + 5'(i), data: 8'hC1 + 8'(i)});
        tick();
        spi_byte_valid = 1'b0;
        spi_data       = 8'hEE;
      end
      wait_req(ok);
      repeat (15) tick();
      chk("to_err_early", err, 0);
      chk("to_req_still", spi_byte_req, 1);
      tick();
      chk("to_err", err, 1);
      chk("to_err_busy", busy, 1);
      chk("to_err_req", spi_byte_req, 0);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk("to_ack_err", err, 0);
      chk("to_ack_idle", busy, 0);
    end
`endif

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_rec_buffer_ctrl.md
Name: spi_rec_buffer_ctrl

Overview:
Sequencer for the SPI receive frame buffer. On a start pulse it clears the buffer, requests NUM_BYTES bytes one at a time from the SPI master, and steers each returned byte into buffer slots FIRST_ADDR.. via buffer_en/addr. It then holds frame_ready until the CAN-side transmit logic acknowledges the assembled 76-bit frame. It sits between the SPI master and the receive buffer inside the MOPS-Hub SPI bridge.

Parameters:
FIRST_ADDR, 3, buffer address of the first data byte slot
NUM_BYTES, 5, bytes per frame, 1..8
CLEAR_ADDR, 0, out-of-range buffer address; writing it clears all data slots
TIMEOUT_CYC, 1024, REQ-state cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active low
start  in  1  one-cycle request to begin a frame
spi_byte_req  out  1  request next byte from SPI master
spi_byte_idx  out  3  index of the byte being requested, 0..NUM_BYTES-1
spi_byte_valid  in  1  SPI master: data_rec_in valid this cycle
buffer_en  out  1  buffer write strobe
addr  out  5  buffer slot address
busy  out  1  frame in progress (not IDLE)
frame_ready  out  1  all bytes stored; frame output is valid
frame_ack  in  1  consumer has taken the frame
err  out  1  frame aborted by timeout (always 0 without the optional feature)

Behaviour:
- Reset (async, rst=0): state IDLE, cnt=0; all outputs 0, addr=CLEAR_ADDR.
- States: IDLE, CLEAR, REQ, GAP, DONE, ERR. cnt is 3 bits.
- IDLE: start=1 -> CLEAR. Otherwise hold.
- CLEAR (1 cycle): buffer_en=1, addr=CLEAR_ADDR. The buffer's default path zeros all data slots. cnt<=0. Next state REQ.
- REQ: spi_byte_req=1, spi_byte_idx=cnt, addr=FIRST_ADDR+cnt (5-bit add, no wrap for legal parameters).
  - buffer_en = spi_byte_valid (combinational, same cycle). The data byte is captured at that edge.
  - On valid with cnt==NUM_BYTES-1 -> DONE. Otherwise cnt<=cnt+1 -> GAP.
- GAP (1 cycle): spi_byte_req=0, buffer_en=0 -> REQ. Guarantees request deassertion between bytes.
- DONE: frame_ready=1. On frame_ack -> IDLE with frame_ready cleared on the next cycle.
- busy=1 in every state except IDLE.
- Output timing: spi_byte_req, frame_ready, busy and err are decoded from registered state. Only buffer_en depends on an input.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start and frame_ack together in DONE: ack honoured, start dropped.
  - spi_byte_valid outside REQ: ignored, no buffer write.
  - frame_ack outside DONE/ERR: ignored.
  - NUM_BYTES=1: CLEAR, REQ, then DONE. GAP is never entered.
  - Reset mid-frame: immediate return to IDLE. Buffer contents are not cleared by this block; the next CLEAR zeros them.
- Latency: start to first spi_byte_req = 2 cycles. Frame time = 2 + sum(byte waits) + (NUM_BYTES-1) GAP cycles.

Optional Feature:
SPI_TIMEOUT_EN
- Defined:
  - A 10-bit-min (clog2 TIMEOUT_CYC) watchdog counts while in REQ and resets on every REQ entry.
  - Reaching TIMEOUT_CYC-1 without valid -> ERR.
  - ERR: err=1, busy=1, spi_byte_req=0. frame_ack -> IDLE. Partial buffer contents are left as-is.
- Undefined: no counter, ERR unreachable, err tied 0, REQ waits indefinitely.

Decomposition:
- Shared package (mopshub_spi_pkg):
  - state enum encoding (IDLE=0, CLEAR=1, REQ=2, GAP=3, DONE=4, ERR=5)
  - FIRST_ADDR/CLEAR_ADDR defaults
  - frame width constant 76
- One natural sub-module: spi_rec_timeout_cnt (watchdog counter with clear/enable/expire), instantiated only under SPI_TIMEOUT_EN.
- FSM and address generation stay in the top module.

Test Plan:
- Reset release, then start; SPI returns bytes 0xA1..0xA5 each 3 cycles after req.
  - CLEAR write to addr 0, then buffer_en at addr 3..7 with the matching byte.
  - frame_ready rises 1 cycle after the 5th valid; buffer output bytes = A1 A2 A3 A4 A5.
- start pulsed in REQ and again in DONE with frame_ack simultaneous -> no restart, IDLE after ack, busy=0.
- spi_byte_valid pulsed in IDLE and GAP -> buffer_en stays 0, no slot changes.
- rst low after byte 2 stored, then new frame with bytes 0x11..0x15 -> CLEAR zeros stale 0xA1/0xA2, final bytes 11..15.
- NUM_BYTES=1 build -> single req at addr 3, frame_ready after one byte, GAP never visited.
- SPI_TIMEOUT_EN, TIMEOUT_CYC=16, no valid on byte 3 -> err=1 exactly 16 cycles after REQ entry; frame_ack returns to IDLE with err=0.
